// File: rtl/fetch_pkg.sv
// Shared constants and the buffered fetch entry type for the instruction fetch stage.
package fetch_pkg;
    localparam int                 XLEN      = 64;
    localparam int                 INSTR_W   = 32;
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;
    localparam int                 PC_STEP   = 4;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with wrap-bit pointers; head is presented combinationally.
module fetch_fifo #(
    parameter int W     = 96,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_i,
    input  logic [W-1:0]           data_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    output logic [W-1:0]           head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    logic         do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign head_o  = mem_q[rd_ptr_q[AW-1:0]];

    // Flush discards everything, including a push or pop requested in the same cycle.
    assign do_push = push_i && !full_o && !flush_i;
    assign do_pop  = pop_i && !empty_o && !flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush_i) begin
            rd_ptr_d = wr_ptr_q;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= data_i;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word fetches and buffers returned
// instructions with their PCs for decode; redirects flush and restart fetch.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 64,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [31:0]     imem_resp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            id_valid,
    input  logic            id_ready,
    output logic [31:0]     id_instr,
    output logic [XLEN-1:0] id_pc
);
    localparam int              CW      = $clog2(DEPTH) + 1;
    localparam logic [CW:0]     CREDITS = (CW+1)'(DEPTH);
    localparam logic [CW-1:0]   ONE     = CW'(1);
    localparam logic [XLEN-1:0] ALIGN_M = ~(XLEN'(PC_STEP - 1));

    logic [XLEN-1:0] pc_q, pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d;
    logic [CW-1:0]   kill_q, kill_d;
    logic [CW-1:0]   buf_count, tag_count;
    logic            buf_empty, buf_full, tag_empty, tag_full;
    logic [XLEN-1:0] tag_head;
    fetch_entry_t    push_entry, head_entry;
    logic            req_fire, resp_live, resp_push, id_fire;

    // Credits come from registered state only, so a response or pop this cycle frees space next cycle.
    assign imem_req_valid = !reset && !redirect_valid &&
                            (({1'b0, outstanding_q} + {1'b0, buf_count}) < CREDITS);
    assign imem_req_addr  = pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // A response with nothing outstanding is a leftover from before reset.
    assign resp_live  = imem_resp_valid && (outstanding_q != '0);
    assign resp_push  = resp_live && (kill_q == '0) && !redirect_valid;

    assign id_valid   = !buf_empty;
    assign id_fire    = id_valid && id_ready;
    assign id_instr   = buf_empty ? '0 : head_entry.instr;
    assign id_pc      = buf_empty ? '0 : head_entry.pc;
    assign push_entry = '{pc: tag_head, instr: imem_resp_data};

    always_comb begin
        outstanding_d = outstanding_q;
        if (req_fire && !resp_live)      outstanding_d = outstanding_q + ONE;
        else if (!req_fire && resp_live) outstanding_d = outstanding_q - ONE;

        kill_d = kill_q;
        pc_d   = pc_q;
        if (redirect_valid) begin
            kill_d = outstanding_d;
            pc_d   = redirect_pc & ALIGN_M;
        end else begin
            if (resp_live && (kill_q != '0)) kill_d = kill_q - ONE;
            if (req_fire)                    pc_d   = pc_q + XLEN'(PC_STEP);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            outstanding_q <= '0;
            kill_q        <= '0;
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            kill_q        <= kill_d;
        end
    end

    // Request PCs in issue order; popped by every live response, killed or not.
    fetch_fifo #(
        .W     (XLEN),
        .DEPTH (DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (req_fire),
        .data_i  (pc_q),
        .pop_i   (resp_live),
        .flush_i (1'b0),
        .head_o  (tag_head),
        .count_o (tag_count),
        .empty_o (tag_empty),
        .full_o  (tag_full)
    );

    fetch_fifo #(
        .W     ($bits(fetch_entry_t)),
        .DEPTH (DEPTH)
    ) u_buf_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (resp_push),
        .data_i  (push_entry),
        .pop_i   (id_fire),
        .flush_i (redirect_valid),
        .head_o  (head_entry),
        .count_o (buf_count),
        .empty_o (buf_empty),
        .full_o  (buf_full)
    );

    a_kill_le_out: assert property (@(posedge clk) disable iff (reset)
        kill_q <= outstanding_q);
    a_credit_cap: assert property (@(posedge clk) disable iff (reset)
        ({1'b0, outstanding_q} + {1'b0, buf_count}) <= CREDITS);
    a_id_pc_align: assert property (@(posedge clk) disable iff (reset)
        id_pc[1:0] == 2'b00);
    a_tag_tracks: assert property (@(posedge clk) disable iff (reset)
        (tag_count == outstanding_q) && (tag_empty == (outstanding_q == '0)));
    a_no_overflow: assert property (@(posedge clk) disable iff (reset)
        !(resp_push && buf_full) && !(req_fire && tag_full));
endmodule
